// File: rtl/simd_decode_pipe.sv
// simd_decode_pipe: registered VALU operand/write-enable decoder behind a 2-entry skid buffer.
// Define SIMD_DECODE_ILLEGAL_TRAP_EN to drop illegal instructions and pulse out_illegal instead.

`ifndef SIMD_FMT_VOP1
`define SIMD_FMT_VOP1  8'h01
`endif
`ifndef SIMD_FMT_VOP2
`define SIMD_FMT_VOP2  8'h02
`endif
`ifndef SIMD_FMT_VOPC
`define SIMD_FMT_VOPC  8'h04
`endif
`ifndef SIMD_FMT_VOP3A
`define SIMD_FMT_VOP3A 8'h08
`endif

module simd_decode_pipe #(
  parameter int NUM_SRC = 3,
  parameter int SRC_AW  = 12,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_opcode,
  input  logic [NUM_SRC*SRC_AW-1:0] in_source_addr,
  input  logic [SRC_AW-1:0]         in_sgpr_dest_addr,
  input  logic [5:0]                in_wfid,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [5:0]                out_wfid,
  output logic                      out_vcc_wr_en,
  output logic                      out_vgpr_wr_en,
  output logic                      out_sgpr_wr_en,
  output logic [NUM_SRC*4-1:0]      out_source_mux_select,
  output logic [NUM_SRC-1:0]        out_vgpr_source_rd_en,
  output logic                      out_sgpr_rd_en,
  output logic                      out_exec_rd_en,
  output logic                      out_illegal,
  output logic [CNT_W-1:0]          out_illegal_count
);

  typedef struct packed {
    logic [5:0]           wfid;
    logic                 vcc;
    logic                 vgpr;
    logic                 sgpr;
    logic [NUM_SRC*4-1:0] sel;
    logic [NUM_SRC-1:0]   rd_en;
    logic                 illegal;
  } entry_t;

  entry_t            dec, out_q, skid_q;
  logic              out_v, skid_v;
  logic [CNT_W-1:0]  cnt_q;
  logic              known, bad_src;
  logic [7:0]        fmt;
  logic [11:0]       op;
  logic [SRC_AW-1:0] src;
  logic              accept, enq, deq;
  logic              unused_opcode_bits;

  assign unused_opcode_bits = ^in_opcode[23:12];

  always_comb begin
    fmt     = in_opcode[31:24];
    op      = in_opcode[11:0];
    known   = 1'b0;
    bad_src = 1'b0;
    src     = '0;
    dec     = '0;
    dec.wfid = in_wfid;
    case (fmt)
      `SIMD_FMT_VOP1: if (op == 12'h001) begin known = 1'b1; dec.vgpr = 1'b1; end
      `SIMD_FMT_VOP2: begin
        if (op inside {12'h000, 12'h009, 12'h013, 12'h014, 12'h016, 12'h01A, 12'h01B, 12'h01C}) begin
          known = 1'b1; dec.vgpr = 1'b1;
        end else if (op inside {12'h025, 12'h026, 12'h028}) begin
          known = 1'b1; dec.vcc = 1'b1; dec.vgpr = 1'b1;
        end
      end
      `SIMD_FMT_VOPC: if (op inside {[12'h080:12'h087], [12'h0C0:12'h0C7]}) begin
        known = 1'b1; dec.vcc = 1'b1;
      end
      `SIMD_FMT_VOP3A: begin
        if (op inside {[12'h080:12'h087], [12'h0C0:12'h0C7]}) begin
          known = 1'b1; dec.vcc = 1'b1; dec.sgpr = 1'b1;
        end else if (op inside {12'h109, 12'h113, 12'h114, 12'h11B, 12'h148, 12'h14A,
                                12'h169, 12'h16A, 12'h16B}) begin
          known = 1'b1; dec.vgpr = 1'b1;
        end
        // The explicit scalar destination decides whether the result lands in VCC or an SGPR.
        if (known) begin
          if (in_sgpr_dest_addr == SRC_AW'(12'hE01)) begin
            dec.vcc = 1'b1; dec.sgpr = 1'b0;
          end else if (in_sgpr_dest_addr[SRC_AW-1 -: 3] == 3'b110) begin
            dec.vcc = 1'b0; dec.sgpr = 1'b1;
          end
        end
      end
      default: ;
    endcase

    for (int i = 0; i < NUM_SRC; i++) begin
      src = in_source_addr[i*SRC_AW +: SRC_AW];
      dec.sel[i*4 +: 4] = 4'b1111;
      if (src == SRC_AW'(12'h7FF))                 dec.sel[i*4 +: 4] = 4'b0000;
      else if (src[SRC_AW-1 -: 2] == 2'b00)        dec.sel[i*4 +: 4] = 4'b0001;
      else if (src[SRC_AW-1 -: 2] == 2'b10) begin
        dec.sel[i*4 +: 4] = 4'b0010;
        dec.rd_en[i]      = 1'b1;
      end
      else if (src[SRC_AW-1 -: 3] == 3'b110)       dec.sel[i*4 +: 4] = 4'b0011;
      else begin
        case (src)
          SRC_AW'(12'hE01): dec.sel[i*4 +: 4] = 4'b0100;
          SRC_AW'(12'hE02): dec.sel[i*4 +: 4] = 4'b0101;
          SRC_AW'(12'hE04): dec.sel[i*4 +: 4] = 4'b0110;
          SRC_AW'(12'hE08): dec.sel[i*4 +: 4] = 4'b0111;
          SRC_AW'(12'hE10): dec.sel[i*4 +: 4] = 4'b1000;
          SRC_AW'(12'hE20): dec.sel[i*4 +: 4] = 4'b1001;
          SRC_AW'(12'hE40): dec.sel[i*4 +: 4] = 4'b1010;
          SRC_AW'(12'hE80): dec.sel[i*4 +: 4] = 4'b1011;
          default:          bad_src = 1'b1;
        endcase
      end
    end

    dec.illegal = !known || bad_src;
    if (dec.illegal) begin
      dec.vcc = 1'b0; dec.vgpr = 1'b0; dec.sgpr = 1'b0;
    end
  end

  assign in_ready = !skid_v;
  assign accept   = in_valid && !skid_v;
  assign deq      = out_v && out_ready;
`ifdef SIMD_DECODE_ILLEGAL_TRAP_EN
  assign enq = accept && !dec.illegal;
`else
  assign enq = accept;
`endif

  // The skid entry is always older than anything arriving, so it refills the output stage first.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else if (!out_v || deq) begin
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        out_v <= enq;
        if (enq) out_q <= dec;
      end
    end else if (enq) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                        cnt_q <= '0;
    else if (accept && dec.illegal && cnt_q != '1)  cnt_q <= cnt_q + CNT_W'(1);
  end

`ifdef SIMD_DECODE_ILLEGAL_TRAP_EN
  logic       trap_q;
  logic [5:0] trap_wfid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      trap_q      <= 1'b0;
      trap_wfid_q <= '0;
    end else begin
      trap_q <= accept && dec.illegal;
      if (accept && dec.illegal) trap_wfid_q <= in_wfid;
    end
  end

  assign out_illegal = trap_q;
  assign out_wfid    = trap_q ? trap_wfid_q : out_q.wfid;
`else
  assign out_illegal = out_v && out_q.illegal;
  assign out_wfid    = out_q.wfid;
`endif

  assign out_valid             = out_v;
  assign out_vcc_wr_en         = out_v && out_q.vcc;
  assign out_vgpr_wr_en        = out_v && out_q.vgpr;
  assign out_sgpr_wr_en        = out_v && out_q.sgpr;
  assign out_source_mux_select = out_q.sel;
  assign out_vgpr_source_rd_en = out_v ? out_q.rd_en : '0;
  assign out_sgpr_rd_en        = out_v;
  assign out_exec_rd_en        = out_v;
  assign out_illegal_count     = cnt_q;

endmodule

// File: tb/tb_simd_decode_pipe.sv
// tb_simd_decode_pipe: directed scoreboard bench for simd_decode_pipe (default build, trap macro undefined).
`timescale 1ns/1ps

module tb_simd_decode_pipe;
  localparam int NUM_SRC = 3;
  localparam int SRC_AW  = 12;
  localparam int CNT_W   = 16;
  localparam logic [7:0] FMT_VOP1  = 8'h01;
  localparam logic [7:0] FMT_VOP2  = 8'h02;
  localparam logic [7:0] FMT_VOPC  = 8'h04;
  localparam logic [7:0] FMT_VOP3A = 8'h08;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_opcode = '0;
  logic [35:0] in_source_addr = '0;
  logic [11:0] in_sgpr_dest_addr = '0;
  logic [5:0]  in_wfid = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_wfid;
  logic        out_vcc_wr_en, out_vgpr_wr_en, out_sgpr_wr_en;
  logic [11:0] out_source_mux_select;
  logic [2:0]  out_vgpr_source_rd_en;
  logic        out_sgpr_rd_en, out_exec_rd_en, out_illegal;
  logic [15:0] out_illegal_count;

  int errors = 0;
  int checks = 0;
  logic [24:0] sb[$];
  logic [24:0] next_exp = '0;
  bit          use_model = 1'b1;
  logic [15:0] exp_cnt = '0;
  int          waits;

  always #5 clk = ~clk;

  simd_decode_pipe #(.NUM_SRC(NUM_SRC), .SRC_AW(SRC_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_source_addr(in_source_addr), .in_sgpr_dest_addr(in_sgpr_dest_addr), .in_wfid(in_wfid),
    .out_valid(out_valid), .out_ready(out_ready), .out_wfid(out_wfid),
    .out_vcc_wr_en(out_vcc_wr_en), .out_vgpr_wr_en(out_vgpr_wr_en), .out_sgpr_wr_en(out_sgpr_wr_en),
    .out_source_mux_select(out_source_mux_select), .out_vgpr_source_rd_en(out_vgpr_source_rd_en),
    .out_sgpr_rd_en(out_sgpr_rd_en), .out_exec_rd_en(out_exec_rd_en),
    .out_illegal(out_illegal), .out_illegal_count(out_illegal_count)
  );

  // Reference decode: {wfid, vcc, vgpr, sgpr, selects, rd_en, illegal}
  function automatic logic [24:0] model(input logic [31:0] opc, input logic [35:0] srcs,
                                        input logic [11:0] dest, input logic [5:0] wfid);
    logic [7:0]  f;
    logic [11:0] o, s;
    logic [2:0]  we, rd;
    logic [11:0] sels;
    bit ok, bad;
    f = opc[31:24]; o = opc[11:0];
    we = 3'b000; rd = 3'b000; sels = '0; ok = 1'b0; bad = 1'b0;
    if (f == FMT_VOP1 && o == 12'h001) begin ok = 1'b1; we = 3'b010; end
    if (f == FMT_VOP2 && (o inside {12'h000, 12'h009, 12'h013, 12'h014, 12'h016, 12'h01A, 12'h01B, 12'h01C}))
      begin ok = 1'b1; we = 3'b010; end
    if (f == FMT_VOP2 && (o inside {12'h025, 12'h026, 12'h028})) begin ok = 1'b1; we = 3'b110; end
    if (f == FMT_VOPC && ((o >= 12'h080 && o <= 12'h087) || (o >= 12'h0C0 && o <= 12'h0C7)))
      begin ok = 1'b1; we = 3'b100; end
    if (f == FMT_VOP3A && ((o >= 12'h080 && o <= 12'h087) || (o >= 12'h0C0 && o <= 12'h0C7)))
      begin ok = 1'b1; we = 3'b101; end
    if (f == FMT_VOP3A && (o inside {12'h109, 12'h113, 12'h114, 12'h11B, 12'h148, 12'h14A, 12'h169, 12'h16A, 12'h16B}))
      begin ok = 1'b1; we = 3'b010; end
    if (f == FMT_VOP3A && ok) begin
      if (dest == 12'hE01) begin we[2] = 1'b1; we[0] = 1'b0; end
      else if (dest[11:9] == 3'b110) begin we[2] = 1'b0; we[0] = 1'b1; end
    end
    for (int i = 0; i < 3; i++) begin
      s = srcs[i*12 +: 12];
      if (s == 12'h7FF) sels[i*4 +: 4] = 4'h0;
      else if (s[11:10] == 2'b00) sels[i*4 +: 4] = 4'h1;
      else if (s[11:10] == 2'b10) begin sels[i*4 +: 4] = 4'h2; rd[i] = 1'b1; end
      else if (s[11:9] == 3'b110) sels[i*4 +: 4] = 4'h3;
      else begin
        sels[i*4 +: 4] = 4'hF;
        bad = 1'b1;
        for (int k = 0; k < 8; k++)
          if (s == (12'hE00 | (12'h001 << k))) begin sels[i*4 +: 4] = 4'(4 + k); bad = 1'b0; end
      end
    end
    if (!ok || bad) we = 3'b000;
    return {wfid, we, sels, rd, (!ok || bad)};
  endfunction

  // Scoreboard: compare on the cycle an output transfer is pending, push on the cycle an accept is pending.
  always @(negedge clk) begin
    logic [24:0] exp_v;
    logic [24:0] obs_v;
    if (rst) begin
      sb.delete();
      exp_cnt = '0;
    end else begin
      if (out_valid && out_ready) begin
        obs_v = {out_wfid, out_vcc_wr_en, out_vgpr_wr_en, out_sgpr_wr_en,
                 out_source_mux_select, out_vgpr_source_rd_en, out_illegal};
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $error("[TB] FAIL unexpected_output observed=%h expected=none", obs_v);
        end else begin
          exp_v = sb.pop_front();
          assert (obs_v === exp_v) else begin
            errors++;
            $error("[TB] FAIL decode_wfid%0d observed=%h expected=%h", exp_v[24:19], obs_v, exp_v);
          end
        end
        checks++;
        assert ({out_sgpr_rd_en, out_exec_rd_en} === 2'b11) else begin
          errors++;
          $error("[TB] FAIL rd_en_tieoff observed=%b expected=11", {out_sgpr_rd_en, out_exec_rd_en});
        end
      end
      if (in_valid && in_ready) begin
        exp_v = use_model ? model(in_opcode, in_source_addr, in_sgpr_dest_addr, in_wfid) : next_exp;
        sb.push_back(exp_v);
        if (exp_v[0] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one instruction starting just after a rising edge; returns just after the accepting edge.
  task automatic apply_stimulus(input logic [31:0] opc, input logic [35:0] srcs, input logic [11:0] dest,
                                input logic [5:0] wfid, input bit model_en, input logic [24:0] exp,
                                output int n_wait);
    in_opcode = opc; in_source_addr = srcs; in_sgpr_dest_addr = dest; in_wfid = wfid;
    use_model = model_en; next_exp = exp; in_valid = 1'b1;
    n_wait = 0;
    @(negedge clk);
    while (!in_ready && n_wait < 50) begin
      n_wait++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout wfid=%0d observed in_ready=0 expected 1", wfid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("drain", sb.size(), 0);
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_in_ready", in_ready, 1);
    check_output("rst_count", out_illegal_count, 0);
    check_output("rst_illegal", out_illegal, 0);
    check_output("rst_wfid", out_wfid, 0);
    check_output("rst_wr_en", {out_vcc_wr_en, out_vgpr_wr_en, out_sgpr_wr_en}, 0);
    check_output("rst_sel", out_source_mux_select, 0);
    check_output("rst_rd_en", out_vgpr_source_rd_en, 0);

    out_ready = 1'b1;
    apply_stimulus({FMT_VOP2, 12'h0, 12'h025}, {12'h0C1, 12'h805, 12'h7FF}, 12'h0, 6'd1, 0,
                   {6'd1, 3'b110, 12'h120, 3'b010, 1'b0}, waits);
    check_output("latency_valid", out_valid, 1);
    apply_stimulus({FMT_VOP3A, 12'h0, 12'h0C2}, {12'h807, 12'h806, 12'h805}, 12'hE01, 6'd2, 0,
                   {6'd2, 3'b100, 12'h222, 3'b111, 1'b0}, waits);
    apply_stimulus({FMT_VOP3A, 12'h0, 12'h0C2}, {12'h807, 12'h806, 12'h805}, 12'hC04, 6'd3, 0,
                   {6'd3, 3'b001, 12'h222, 3'b111, 1'b0}, waits);
    apply_stimulus({FMT_VOP2, 12'h0, 12'h0FF}, {12'h805, 12'h805, 12'hE03}, 12'h0, 6'd4, 0,
                   {6'd4, 3'b000, 12'h22F, 3'b110, 1'b1}, waits);
    check_output("count_first_illegal", out_illegal_count, 1);
    apply_stimulus({FMT_VOP1, 12'h0, 12'h001}, {12'h400, 12'h0C1, 12'h805}, 12'h0, 6'd5, 0,
                   {6'd5, 3'b000, 12'hF12, 3'b001, 1'b1}, waits);
    check_output("count_bad_source", out_illegal_count, 2);

    apply_stimulus({FMT_VOPC, 12'h0, 12'h087}, {12'hE01, 12'hE04, 12'hE02}, 12'h0, 6'd6, 1, '0, waits);
    apply_stimulus({FMT_VOPC, 12'h0, 12'h088}, {12'h001, 12'h001, 12'h001}, 12'h0, 6'd7, 1, '0, waits);
    apply_stimulus({FMT_VOP3A, 12'h0, 12'h080}, {12'hE20, 12'hE10, 12'hE08}, 12'h100, 6'd8, 1, '0, waits);
    apply_stimulus({FMT_VOP3A, 12'h0, 12'h16B}, {12'h000, 12'hE80, 12'hE40}, 12'hE01, 6'd9, 1, '0, waits);
    apply_stimulus({FMT_VOP3A, 12'h0, 12'h16C}, {12'h805, 12'h805, 12'h805}, 12'h0, 6'd10, 1, '0, waits);
    apply_stimulus({FMT_VOP1, 12'h0, 12'h002}, {12'h805, 12'h805, 12'h805}, 12'h0, 6'd11, 1, '0, waits);
    apply_stimulus({FMT_VOP2, 12'h0, 12'h028}, {12'h3FF, 12'h7FE, 12'hC00}, 12'h0, 6'd12, 1, '0, waits);
    apply_stimulus({8'h00, 12'h0, 12'h025}, {12'h805, 12'h805, 12'h805}, 12'h0, 6'd13, 1, '0, waits);
    drain();
    check_output("count_mixed", out_illegal_count, {16'h0, exp_cnt});

    // Eight back-to-back instructions while the consumer stalls for three cycles.
    fork
      begin
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int k = 0; k < 8; k++) begin
          apply_stimulus({FMT_VOP2, 12'h0, 12'h009}, {12'h800 + 12'(k), 12'h0C0, 12'h7FF}, 12'h0,
                         6'(20 + k), 1, '0, waits);
          if (k == 1) begin
            check_output("second_accept_wait", waits, 0);
            check_output("in_ready_drop", in_ready, 0);
          end
        end
      end
    join
    drain();

    for (int k = 0; k < 4; k++) begin
      apply_stimulus({FMT_VOP3A, 12'h0, 12'h148}, {12'h805, 12'hC01, 12'h002}, 12'h0, 6'(30 + k), 1, '0, waits);
      check_output("throughput_wait", waits, 0);
    end
    drain();

    // Fill both entries, then reset: neither held instruction may come out.
    out_ready = 1'b0;
    apply_stimulus({FMT_VOP1, 12'h0, 12'h001}, {12'h805, 12'h805, 12'h805}, 12'h0, 6'd40, 1, '0, waits);
    apply_stimulus({FMT_VOP1, 12'h0, 12'h001}, {12'h806, 12'h806, 12'h806}, 12'h0, 6'd41, 1, '0, waits);
    check_output("full_in_ready", in_ready, 0);
    check_output("full_out_valid", out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_output("midrst_out_valid", out_valid, 0);
    check_output("midrst_in_ready", in_ready, 1);
    check_output("midrst_count", out_illegal_count, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_output("midrst_no_output", out_valid, 0);
    end

    for (int k = 0; k < 65534; k++)
      apply_stimulus({FMT_VOP2, 12'h0, 12'h0FF}, {12'h805, 12'h805, 12'h805}, 12'h0, 6'(k), 1, '0, waits);
    check_output("count_below_sat", out_illegal_count, 16'hFFFE);
    apply_stimulus({FMT_VOP2, 12'h0, 12'h0FF}, {12'h805, 12'h805, 12'h805}, 12'h0, 6'd1, 1, '0, waits);
    check_output("count_at_sat", out_illegal_count, 16'hFFFF);
    for (int k = 0; k < 4; k++)
      apply_stimulus({FMT_VOP2, 12'h0, 12'h0FF}, {12'h805, 12'h805, 12'h805}, 12'h0, 6'(k), 1, '0, waits);
    check_output("count_held_sat", out_illegal_count, 16'hFFFF);
    drain();

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
